// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU control and multi-cycle multiplier.
// ALU control codes, ALUOp classes, decode patterns and FSM states.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUCTRL_ADD  = 3'b000;
    localparam logic [2:0] ALUCTRL_SUB  = 3'b001;
    localparam logic [2:0] ALUCTRL_AND  = 3'b010;
    localparam logic [2:0] ALUCTRL_XOR  = 3'b011;
    localparam logic [2:0] ALUCTRL_MUL  = 3'b100;
    localparam logic [2:0] ALUCTRL_SLL  = 3'b101;
    localparam logic [2:0] ALUCTRL_SRA  = 3'b110;
    localparam logic [2:0] ALUCTRL_LDST = 3'b111;

    localparam logic [1:0] ALUOP_R  = 2'b00;
    localparam logic [1:0] ALUOP_I  = 2'b01;
    localparam logic [1:0] ALUOP_S  = 2'b10;
    localparam logic [1:0] ALUOP_SB = 2'b11;

    localparam logic [9:0] F10_ADD = 10'b0000000_000;
    localparam logic [9:0] F10_SUB = 10'b0100000_000;
    localparam logic [9:0] F10_AND = 10'b0000000_111;
    localparam logic [9:0] F10_XOR = 10'b0000000_100;
    localparam logic [9:0] F10_MUL = 10'b0000001_000;
    localparam logic [9:0] F10_SLL = 10'b0000000_001;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_ctrl_mc_mul_iter.sv
// Iterative shift-add multiplier datapath, BPC multiplier bits per step.
// Produces the low XLEN bits of the product; start/step come from the FSM.
module alu_ctrl_mc_mul_iter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int BPC        = 1,
    parameter int EARLY_TERM = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_mcand,
    input  logic [XLEN-1:0] i_mplier,
    output logic            o_last,
    output logic [XLEN-1:0] o_result
);

    localparam int NITER = XLEN / BPC;
    localparam int CNT_W = (NITER > 1) ? $clog2(NITER) : 1;

    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_result;

    logic [XLEN-1:0]  w_partial;
    logic [XLEN-1:0]  w_acc_nxt;
    logic [XLEN-1:0]  w_mplier_nxt;
    logic [XLEN-1:0]  w_mcand_nxt;

    // Chunk product mcand * mplier[BPC-1:0] as a small shift-add tree.
    always_comb begin
        w_partial = '0;
        for (int b = 0; b < BPC; b++) begin
            if (r_mplier[b]) begin
                w_partial = w_partial + (r_mcand << b);
            end
        end
    end

    assign w_acc_nxt    = r_acc + w_partial;
    assign w_mplier_nxt = r_mplier >> BPC;
    assign w_mcand_nxt  = r_mcand << BPC;

    assign o_last = (r_cnt == CNT_W'(NITER - 1)) |
                    ((EARLY_TERM != 0) & (w_mplier_nxt == '0));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (o_last) begin
                r_result <= w_acc_nxt;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/alu_ctrl_mc.sv
// EX-stage ALU control decode plus the multi-cycle MUL sequencer FSM.
// Stalls IF/ID/EX while a MUL iterates; product bypasses the ALU.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int BPC        = 1,
    parameter int EARLY_TERM = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [9:0]      funct_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic [2:0]      ALUCtrl_o,
    output logic            illegal_o,
    output logic            stall_o,
    output logic            mul_valid_o,
    output logic [XLEN-1:0] mul_result_o
);

    state_e     r_state;
    state_e     w_next;
    logic [2:0] w_ctrl;
    logic       w_legal;
    logic       w_is_mul;
    logic       w_accept;
    logic       w_step;
    logic       w_last;

    always_comb begin
        w_ctrl  = ALUCTRL_ADD;
        w_legal = 1'b0;
        unique case (1'b1)
            (ALUOp_i == ALUOP_R): begin
                w_legal = 1'b1;
                case (funct_i)
                    F10_ADD: w_ctrl = ALUCTRL_ADD;
                    F10_SUB: w_ctrl = ALUCTRL_SUB;
                    F10_AND: w_ctrl = ALUCTRL_AND;
                    F10_XOR: w_ctrl = ALUCTRL_XOR;
                    F10_MUL: w_ctrl = ALUCTRL_MUL;
                    F10_SLL: w_ctrl = ALUCTRL_SLL;
                    default: w_legal = 1'b0;
                endcase
            end
            (ALUOp_i == ALUOP_I): begin
                w_legal = 1'b1;
                case (funct_i[2:0])
                    F3_ADDI: w_ctrl = ALUCTRL_ADD;
                    F3_SRAI: w_ctrl = ALUCTRL_SRA;
                    F3_LW:   w_ctrl = ALUCTRL_LDST;
                    default: w_legal = 1'b0;
                endcase
            end
            (ALUOp_i == ALUOP_S): begin
                if (funct_i[2:0] == F3_SW) begin
                    w_ctrl  = ALUCTRL_LDST;
                    w_legal = 1'b1;
                end
            end
            (ALUOp_i == ALUOP_SB): begin
                if (funct_i[2:0] == F3_BEQ) begin
                    w_ctrl  = ALUCTRL_SUB;
                    w_legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ALUCtrl_o = w_ctrl;
    assign illegal_o = valid_i & ~w_legal;

    assign w_is_mul = valid_i & (ALUOp_i == ALUOP_R) & (funct_i == F10_MUL);
    // DONE deliberately ignores is_mul so the held MUL does not restart.
    assign w_accept = (r_state == ST_IDLE) & w_is_mul & ~flush_i;
    assign w_step   = (r_state == ST_BUSY) & ~flush_i;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_BUSY;
            ST_BUSY: if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush_i) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign stall_o     = rst_i & (w_accept | (r_state == ST_BUSY));
    assign mul_valid_o = (r_state == ST_DONE) & ~flush_i;

    alu_ctrl_mc_mul_iter #(
        .XLEN       (XLEN),
        .BPC        (BPC),
        .EARLY_TERM (EARLY_TERM)
    ) u_mul_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_start  (w_accept),
        .i_step   (w_step),
        .i_mcand  (rs1_data_i),
        .i_mplier (rs2_data_i),
        .o_last   (w_last),
        .o_result (mul_result_o)
    );

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Bench for alu_ctrl_mc: four BPC/EARLY_TERM configurations side by side.
// Random decode and MUL traffic checked against a plain arithmetic model.
module tb_alu_ctrl_mc;

    localparam logic [9:0] MULF = 10'b0000001000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  vld;
    logic [9:0]  funct;
    logic [1:0]  aluop;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;

    wire  [3:0]  ill;
    wire  [3:0]  st;
    wire  [3:0]  mv;
    wire  [2:0]  ctrl [4];
    wire  [31:0] res  [4];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // dut0: BPC1 ET1, dut1: BPC1 ET0, dut2: BPC2 ET1, dut3: BPC4 ET0
    for (genvar g = 0; g < 4; g++) begin : g_dut
        alu_ctrl_mc #(
            .XLEN       (32),
            .BPC        ((g == 3) ? 4 : ((g == 2) ? 2 : 1)),
            .EARLY_TERM ((g == 0 || g == 2) ? 1 : 0)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst_i),
            .valid_i      (vld[g]),
            .funct_i      (funct),
            .ALUOp_i      (aluop),
            .rs1_data_i   (rs1),
            .rs2_data_i   (rs2),
            .flush_i      (flush),
            .ALUCtrl_o    (ctrl[g]),
            .illegal_o    (ill[g]),
            .stall_o      (st[g]),
            .mul_valid_o  (mv[g]),
            .mul_result_o (res[g])
        );
    end

    function automatic int bpc_of(input int d);
        return (d == 3) ? 4 : ((d == 2) ? 2 : 1);
    endfunction

    function automatic bit et_of(input int d);
        return (d == 0 || d == 2);
    endfunction

    // Number of BUSY cycles: all chunks, or only the chunks that hold set bits.
    function automatic int lat_model(input int d, input logic [31:0] b);
        int n;
        int bl;
        int k;
        n  = 32 / bpc_of(d);
        if (!et_of(d)) return n;
        bl = 0;
        for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
        k = (bl + bpc_of(d) - 1) / bpc_of(d);
        if (k < 1) k = 1;
        return k;
    endfunction

    // Returns {illegal, ctrl} from the instruction table.
    function automatic logic [3:0] dec_model(input logic [1:0] op,
                                             input logic [9:0] f,
                                             input logic v);
        int c;
        c = -1;
        if (op == 2'b00) begin
            if (f == 10'b0000000000) c = 0;
            if (f == 10'b0100000000) c = 1;
            if (f == 10'b0000000111) c = 2;
            if (f == 10'b0000000100) c = 3;
            if (f == 10'b0000001000) c = 4;
            if (f == 10'b0000000001) c = 5;
        end else if (op == 2'b01) begin
            if (f[2:0] == 3'd0) c = 0;
            if (f[2:0] == 3'd5) c = 6;
            if (f[2:0] == 3'd2) c = 7;
        end else if (op == 2'b10) begin
            if (f[2:0] == 3'd2) c = 7;
        end else begin
            if (f[2:0] == 3'd0) c = 1;
        end
        if (c < 0) return {v, 3'b000};
        return {1'b0, 3'(c)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic dec_vec(input logic [1:0] op, input logic [9:0] f,
                           input logic v);
        logic [3:0] e;
        @(negedge clk);
        vld   = {3'b000, v};
        aluop = op;
        funct = f;
        flush = 1'b0;
        #1;
        e = dec_model(op, f, v);
        chk($sformatf("dec_ctrl op=%b f=%b", op, f), 32'(ctrl[0]), 32'(e[2:0]));
        chk($sformatf("dec_ill op=%b f=%b v=%b", op, f, v), 32'(ill[0]), 32'(e[3]));
        chk("dec_nostall", 32'(st[0]), 32'd0);
    endtask

    task automatic run_mul(input int d, input logic [31:0] a,
                           input logic [31:0] b);
        logic [31:0] e;
        int k;
        e = a * b;
        k = lat_model(d, b);
        @(posedge clk);
        #1;
        vld    = '0;
        vld[d] = 1'b1;
        aluop  = 2'b00;
        funct  = MULF;
        rs1    = a;
        rs2    = b;
        flush  = 1'b0;
        @(negedge clk);
        chk($sformatf("accept_stall dut%0d", d), 32'(st[d]), 32'd1);
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            chk($sformatf("busy_stall dut%0d c=%0d", d, c), 32'(st[d]), 32'd1);
            chk($sformatf("busy_novalid dut%0d c=%0d", d, c), 32'(mv[d]), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("done_valid dut%0d", d), 32'(mv[d]), 32'd1);
        chk($sformatf("done_stall dut%0d", d), 32'(st[d]), 32'd0);
        chk($sformatf("result dut%0d %h*%h", d, a, b), res[d], e);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        vld   = '0;
        funct = 10'b0;
        aluop = 2'b00;
        flush = 1'b0;
    endtask

    initial begin
        logic [9:0] pool [8];
        logic [1:0] op;
        logic [9:0] f;
        int pulses;

        pool[0] = 10'b0000000000; pool[1] = 10'b0100000000;
        pool[2] = 10'b0000000111; pool[3] = 10'b0000000100;
        pool[4] = 10'b0000000001; pool[5] = 10'b0000000010;
        pool[6] = 10'b0100000101; pool[7] = 10'b0000000011;

        rst_i = 1'b0;
        vld   = '0;
        funct = '0;
        aluop = '0;
        rs1   = '0;
        rs2   = '0;
        flush = 1'b0;
        #2;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_stall dut%0d", d), 32'(st[d]), 32'd0);
            chk($sformatf("rst_valid dut%0d", d), 32'(mv[d]), 32'd0);
            chk($sformatf("rst_result dut%0d", d), res[d], 32'd0);
        end
        @(negedge clk);
        rst_i = 1'b1;

        dec_vec(2'b00, 10'b0100000000, 1'b1);
        dec_vec(2'b01, 10'b0100000101, 1'b1);
        dec_vec(2'b00, 10'b0000000010, 1'b1);
        dec_vec(2'b10, 10'b0000000010, 1'b1);
        dec_vec(2'b11, 10'b0000000000, 1'b1);
        dec_vec(2'b11, 10'b0000000001, 1'b0);
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)]
                                              : 10'($urandom);
            if (op == 2'b00 && f == MULF) f = 10'b0;
            dec_vec(op, f, 1'($urandom_range(0, 1)));
        end
        idle_cycle();

        run_mul(0, 32'd7, 32'd6);
        run_mul(1, 32'd7, 32'd6);
        run_mul(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_mul(0, 32'd3, 32'd5);
        run_mul(0, 32'h12345678, 32'd0);
        run_mul(2, 32'hDEADBEEF, 32'h80000000);
        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 4; d++) begin
                run_mul(d, $urandom, $urandom >> $urandom_range(0, 31));
            end
        end
        idle_cycle();

        // Flush two cycles into a long MUL.
        @(posedge clk); #1;
        vld = 4'b0010; aluop = 2'b00; funct = MULF; rs1 = 32'd9; rs2 = 32'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_novalid", 32'(mv[1]), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        funct = 10'b0;
        @(negedge clk);
        chk("post_flush_stall", 32'(st[1]), 32'd0);
        chk("post_flush_add", 32'(ctrl[1]), 32'd0);
        chk("post_flush_legal", 32'(ill[1]), 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mv[1] !== 1'b0) pulses++;
        end
        chk("flush_no_pulse", 32'(pulses), 32'd0);

        // Flush dominates acceptance in IDLE.
        @(posedge clk); #1;
        funct = MULF; flush = 1'b1;
        @(negedge clk);
        chk("flush_vs_accept_stall", 32'(st[1]), 32'd0);
        @(posedge clk); #1;
        vld = '0; flush = 1'b0;
        @(negedge clk);
        chk("flush_vs_accept_idle", 32'(st[1]), 32'd0);

        // Flush landing in DONE suppresses the pulse.
        @(posedge clk); #1;
        vld = 4'b0001; aluop = 2'b00; funct = MULF; rs1 = 32'd7; rs2 = 32'd6;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done_novalid", 32'(mv[0]), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; vld = '0;
        @(negedge clk);
        chk("flush_done_idle", 32'(st[0]) | 32'(mv[0]), 32'd0);

        // Asynchronous reset mid-MUL.
        @(posedge clk); #1;
        vld = 4'b0010; aluop = 2'b00; funct = MULF; rs1 = 32'd7; rs2 = 32'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(st[1]), 32'd0);
        chk("rst_mid_result", res[1], 32'd0);
        chk("rst_mid_valid", 32'(mv[1]), 32'd0);
        @(negedge clk);
        vld = '0;
        rst_i = 1'b1;
        run_mul(1, 32'd3, 32'd5);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
